// File: rtl/mux_channel_selector.sv
// mux_channel_selector: debounced button and auto-timer driven select for a two-channel mux
module mux_channel_selector #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int AUTO_PERIOD = 12000000,
  parameter bit RESET_SELECTION = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  input  logic auto_mode_enable,
  output logic selection_input,
  output logic selection_changed,
  output logic button_debounced
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = AUTO_PERIOD > 1 ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] A_LAST = AW'(AUTO_PERIOD - 1);
  logic sync1, button_sync, differ, deb_done, press, expiry, toggle;
  logic [DW-1:0] deb_cnt;
  logic [AW-1:0] auto_cnt;
  always_comb begin
    differ   = button_sync != button_debounced;
    deb_done = differ && deb_cnt == D_LAST;
    press    = deb_done && button_sync;
    expiry   = auto_mode_enable && auto_cnt == A_LAST;
    toggle   = press || expiry;
  end
  // a press and an expiry on the same edge merge into one inversion and one counter restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1             <= 1'b0;
      button_sync       <= 1'b0;
      deb_cnt           <= '0;
      button_debounced  <= 1'b0;
      auto_cnt          <= '0;
      selection_input   <= RESET_SELECTION;
      selection_changed <= 1'b0;
    end else begin
      sync1             <= button_raw;
      button_sync       <= sync1;
      deb_cnt           <= (differ && !deb_done) ? deb_cnt + 1'b1 : '0;
      button_debounced  <= deb_done ? button_sync : button_debounced;
      auto_cnt          <= (auto_mode_enable && !toggle) ? auto_cnt + 1'b1 : '0;
      selection_input   <= selection_input ^ toggle;
      selection_changed <= toggle;
    end
  end
endmodule

// File: tb/tb_mux_channel_selector.sv
// tb_mux_channel_selector: randomized and directed checks against a history-based reference model
module tb_mux_channel_selector;
  localparam int D = 4;
  localparam int A = 10;
  logic clk = 1'b0, reset = 1'b0, button_raw = 1'b0, auto_mode_enable = 1'b0;
  logic selection_input, selection_changed, button_debounced;
  int n_checks = 0, n_fails = 0, edge_n = 0;
  logic m_s1, m_s2, m_deb, m_sel, m_chg;
  int m_start;
  logic sq[$];

  mux_channel_selector #(.DEBOUNCE_CYCLES(D), .AUTO_PERIOD(A), .RESET_SELECTION(1'b1)) dut (
    .clk(clk), .reset(reset), .button_raw(button_raw), .auto_mode_enable(auto_mode_enable),
    .selection_input(selection_input), .selection_changed(selection_changed),
    .button_debounced(button_debounced)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b (edge %0d, t=%0t)", tag, act, exp, edge_n, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s.sel", tag), selection_input, m_sel);
    check($sformatf("%s.chg", tag), selection_changed, m_chg);
    check($sformatf("%s.deb", tag), button_debounced, m_deb);
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_sel = 1; m_chg = 0;
    sq.delete();
    m_start = edge_n + 1;
  endtask

  // debounced level flips once the last D synchronised samples all disagree with it;
  // the auto period is measured as edges elapsed since the last restart point
  task automatic model_edge();
    logic all_diff, press, expiry;
    sq.push_back(m_s2);
    if (sq.size() > D) void'(sq.pop_front());
    all_diff = (sq.size() == D);
    foreach (sq[i]) if (sq[i] == m_deb) all_diff = 0;
    press = 0;
    if (all_diff) begin
      m_deb = ~m_deb;
      press = m_deb;
      sq.delete();
    end
    expiry = auto_mode_enable && (edge_n - m_start == A - 1);
    if (press || expiry || !auto_mode_enable) m_start = edge_n + 1;
    m_chg = press || expiry;
    if (m_chg) m_sel = ~m_sel;
    m_s2 = m_s1;
    m_s1 = button_raw;
  endtask

  task automatic step(input logic r, input logic raw, input logic en, input string tag);
    reset = r; button_raw = raw; auto_mode_enable = en;
    @(posedge clk);
    edge_n++;
    if (reset) model_reset(); else model_edge();
    #1 check_all(tag);
  endtask

  initial begin
    logic raw, en, rst;
    reset = 1'b1;
    #1 model_reset();
    check_all("por");
    step(1, 0, 0, "rst_hold");
    for (int c = 0; c < 20; c++) step(0, 0, 0, "idle");
    for (int c = 0; c < 10; c++) step(0, 1, 0, "press");
    for (int c = 0; c < 8; c++) step(0, 0, 0, "release");
    for (int c = 0; c < 20; c++) step(0, c[1], 0, "bounce");
    step(1, 0, 0, "rst");
    for (int c = 0; c < 32; c++) step(0, 0, !(c >= 12 && c < 15), "auto");
    for (int offs = 0; offs < 12; offs++) begin
      step(1, 0, 0, "rst");
      for (int c = 0; c < 25; c++) step(0, c >= offs, 1, "coinc");
    end
    step(1, 0, 0, "rst");
    for (int c = 0; c < 4; c++) step(0, 1, 0, "mid_deb");
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    step(1, 1, 0, "rst_held_btn");
    for (int c = 0; c < 10; c++) step(0, 1, 0, "post_rst");
    raw = 0; en = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) raw = ~raw;
      if ($urandom_range(39) == 0) en = ~en;
      rst = ($urandom_range(499) == 0);
      step(rst, raw, en, "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
